approx_computing_kernel_npp: RTL and testbench

Non-pipelined, iterative fixed-coefficient scaling kernel for the configurable approximate-computing datapath. It accepts one 8-bit sign-magnitude sample and multiplies its magnitude by a constant coefficient with a serial shift-add multiplier over 8 cycles. It returns a 10-bit two's-complement result with a one-cycle valid pulse. One operation is in flight at a time; no pipelining.

---
 rtl/approx_computing_kernel_npp.sv | 125 ++++++++++++
 tb/tb_approx_computing_kernel_npp.sv | 135 +++++++++++++
 2 files changed

// File: rtl/approx_computing_kernel_npp.sv
// Iterative fixed-coefficient scaling kernel: sign-magnitude sample times COEF (Q1.7)
// via an 8-cycle serial shift-add multiplier, returning a 10-bit two's-complement result.
module approx_computing_kernel_npp #(
   parameter logic [7:0] COEF = 8'd192
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] iData,
   input  logic       iSign,
   input  logic       iDataValid,
   output logic [9:0] oData,
   output logic       oDataValid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_r, state_s;
   logic [7:0]  operand_r, operand_s;
   logic        sign_r, sign_s;
   logic [15:0] acc_r, acc_s;
   logic [3:0]  cnt_r, cnt_s;
   logic [9:0]  data_r, data_s;
   logic        valid_r, valid_s;
   logic [15:0] addend_s;
   logic [8:0]  mag_s;

   // Negating a zero magnitude yields zero, so no negative zero can escape.
   function automatic logic [9:0] apply_sign(input logic neg, input logic [8:0] mag);
      logic [9:0] wide;
      wide = {1'b0, mag};
      if (neg) begin
         apply_sign = 10'd0 - wide;
      end else begin
         apply_sign = wide;
      end
   endfunction

   // Partial product for the current multiplicand bit and the truncated Q1.7 magnitude.
   always_comb begin
      addend_s = {8'd0, COEF} << cnt_r[2:0];
      mag_s    = acc_r[15:7];
   end

   // State register.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and datapath next values.
   always_comb begin
      state_s   = state_r;
      operand_s = operand_r;
      sign_s    = sign_r;
      acc_s     = acc_r;
      cnt_s     = cnt_r;
      data_s    = data_r;
      valid_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (iDataValid) begin
               operand_s = iData;
               sign_s    = iSign;
               acc_s     = 16'd0;
               cnt_s     = 4'd0;
               state_s   = BUSY;
            end else begin
               state_s   = IDLE;
            end
         end
         BUSY: begin
            if (operand_r[cnt_r[2:0]]) begin
               acc_s = acc_r + addend_s;
            end else begin
               acc_s = acc_r;
            end
            cnt_s = cnt_r + 4'd1;
            // The eighth BUSY edge processes bit 7 and hands over to DONE.
            if (cnt_r == 4'd7) begin
               state_s = DONE;
            end else begin
               state_s = BUSY;
            end
         end
         DONE: begin
            data_s  = apply_sign(sign_r, mag_s);
            valid_s = 1'b1;
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         operand_r <= 8'd0;
         sign_r    <= 1'b0;
         acc_r     <= 16'd0;
         cnt_r     <= 4'd0;
         data_r    <= 10'd0;
         valid_r   <= 1'b0;
      end else begin
         operand_r <= operand_s;
         sign_r    <= sign_s;
         acc_r     <= acc_s;
         cnt_r     <= cnt_s;
         data_r    <= data_s;
         valid_r   <= valid_s;
      end
   end

   assign oData      = data_r;
   assign oDataValid = valid_r;

endmodule

// File: tb/tb_approx_computing_kernel_npp.sv
// Randomised self-checking bench: two kernel instances (COEF=192 and COEF=255) on shared
// inputs, compared against an arithmetic reference of the scaling function and latency.
module tb_approx_computing_kernel_npp;

   logic       clk;
   logic       rst_n;
   logic [7:0] iData;
   logic       iSign;
   logic       iDataValid;
   logic [9:0] oData_a, oData_b;
   logic       oDataValid_a, oDataValid_b;

   int total_count;
   int bad_count;
   logic [9:0] last_a, last_b;

   approx_computing_kernel_npp #(.COEF(8'd192)) dut_a (
      .clk(clk), .rst_n(rst_n), .iData(iData), .iSign(iSign), .iDataValid(iDataValid),
      .oData(oData_a), .oDataValid(oDataValid_a)
   );

   approx_computing_kernel_npp #(.COEF(8'd255)) dut_b (
      .clk(clk), .rst_n(rst_n), .iData(iData), .iSign(iSign), .iDataValid(iDataValid),
      .oData(oData_b), .oDataValid(oDataValid_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total_count++;
      if (observed !== expected) begin
         bad_count++;
         $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [9:0] ref_result(input int d, input int s, input int coef);
      int m;
      int v;
      m = (d * coef) / 128;
      v = (s != 0) ? -m : m;
      return v[9:0];
   endfunction

   // mode 0: plain op; mode 1: extra valid sampled 3 edges after capture; mode 2: reset in BUSY
   task automatic run_op(input int d, input int s, input int mode);
      logic [9:0] exp_a, exp_b;
      logic       want_pulse;
      exp_a = ref_result(d, s, 192);
      exp_b = ref_result(d, s, 255);
      @(negedge clk);
      iData = d[7:0];
      iSign = s[0];
      iDataValid = 1'b1;
      @(posedge clk);
      #1;
      iDataValid = 1'b0;
      iData = 8'($urandom);
      iSign = 1'($urandom);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (mode == 1 && k == 2) begin
            iData = 8'($urandom);
            iSign = 1'($urandom);
            iDataValid = 1'b1;
         end
         if (mode == 1 && k == 3) iDataValid = 1'b0;
         if (mode == 2 && k == 3) begin
            rst_n = 1'b1;
            last_a = 10'd0;
            last_b = 10'd0;
         end
         if (mode == 2 && k == 5) rst_n = 1'b0;
         want_pulse = (mode != 2) && (k == 9);
         if (want_pulse) begin
            last_a = exp_a;
            last_b = exp_b;
         end
         check_value("valid_a", 32'(oDataValid_a), 32'(want_pulse));
         check_value("valid_b", 32'(oDataValid_b), 32'(want_pulse));
         if (want_pulse || k >= 10 || (mode == 2 && k == 4)) begin
            check_value("data_a", 32'(oData_a), 32'(last_a));
            check_value("data_b", 32'(oData_b), 32'(last_b));
         end
      end
   endtask

   initial begin
      total_count = 0;
      bad_count = 0;
      last_a = 10'd0;
      last_b = 10'd0;
      rst_n = 1'b1;
      iData = 8'd0;
      iSign = 1'b0;
      iDataValid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         iDataValid = 1'($urandom);
         iData = 8'($urandom);
         check_value("rst_valid", 32'(oDataValid_a | oDataValid_b), 32'd0);
         check_value("rst_data", 32'({oData_a, oData_b}), 32'd0);
      end
      @(negedge clk);
      iDataValid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      run_op(128, 0, 0);
      check_value("dir_128_a", 32'(last_a), 32'h0C0);
      repeat (10) @(negedge clk);
      run_op(63, 1, 0);
      check_value("dir_63n_a", 32'(last_a), 32'h3A2);
      run_op(255, 1, 0);
      check_value("dir_255n_a", 32'(last_a), 32'h282);
      run_op(255, 0, 0);
      check_value("dir_255_b", 32'(last_b), 32'h1FC);
      run_op(0, 1, 0);
      run_op(1, 0, 0);
      run_op(200, 0, 1);
      run_op(77, 1, 2);
      run_op(99, 1, 0);

      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0) ? 1 : 0);
      end

      $display("test done: total=%0d bad=%0d", total_count, bad_count);
      $finish;
   end

endmodule
